// File: rtl/reg_write_bank.sv
// Register-file write side: buffers write-back requests in a small FIFO and
// commits one byte-merged write per clock into 32 registers (r0 reads zero).
module reg_write_bank #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be,
    input  logic          hold,
    output logic [1023:0] q_flat,
    output logic [CW-1:0] pending,
    output logic          busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   regs_q [32];
    logic [31:0]   regs_d [32];
    logic [4:0]    addr_q [DEPTH];
    logic [4:0]    addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [3:0]    be_d   [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    assign wr_ready = (count_q != CW'(DEPTH));
    assign push     = wr_valid & wr_ready;
    assign pop      = ~hold & (count_q != '0);
    assign pending  = count_q;
    assign busy     = (count_q != '0);

    always_comb begin
        regs_d   = regs_q;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            addr_d[wr_ptr_q] = wr_addr;
            data_d[wr_ptr_q] = wr_data;
            be_d[wr_ptr_q]   = wr_be;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        // Head entry is read from the pre-edge state, so a same-cycle push never bypasses it.
        if (pop) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[rd_ptr_q][b]) begin
                    regs_d[addr_q[rd_ptr_q]][8*b +: 8] = data_q[rd_ptr_q][8*b +: 8];
                end
            end
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        regs_d[0] = '0;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '{default: '0};
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            be_q     <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            regs_q   <= regs_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        q_flat = '0;
        for (int k = 0; k < 32; k++) begin
            q_flat[32*k +: 32] = regs_q[k];
        end
    end
endmodule

// File: tb/tb_reg_write_bank.sv
// Bench for reg_write_bank: directed test-plan steps followed by a randomized
// phase, all compared against a queue/array reference model.
module tb_reg_write_bank;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic          hold;
    logic [1023:0] q_flat;
    logic [CW-1:0] pending;
    logic          busy;

    reg_write_bank #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .hold     (hold),
        .q_flat   (q_flat),
        .pending  (pending),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mregs[32];
    int          vectors;
    int          miscompares;

    task automatic chk(input string name, input logic [1023:0] obs, input logic [1023:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [1023:0] model_flat();
        logic [1023:0] f;
        for (int k = 0; k < 32; k++) f[32*k +: 32] = mregs[k];
        return f;
    endfunction

    function automatic logic [31:0] reg_of(input int k);
        return q_flat[32*k +: 32];
    endfunction

    // One clock: drive inputs, check ready before the edge, advance the model, check after.
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic h, input logic r);
        logic acc;
        logic com;
        ent_t e;
        wr_valid = v; wr_addr = a; wr_data = d; wr_be = be; hold = h; rst = r;
        acc = v && (mq.size() < DEPTH);
        com = !h && (mq.size() > 0);
        if (!r) chk("ready_pre", wr_ready, mq.size() != DEPTH);
        @(posedge clk);
        if (r) begin
            mq.delete();
            for (int k = 0; k < 32; k++) mregs[k] = '0;
        end else begin
            if (com) begin
                e = mq.pop_front();
                if (e.a != 0)
                    for (int b = 0; b < 4; b++)
                        if (e.be[b]) mregs[e.a][8*b +: 8] = e.d[8*b +: 8];
            end
            if (acc) mq.push_back('{a: a, d: d, be: be});
        end
        #1;
        chk("q_flat", q_flat, model_flat());
        chk("pending", pending, mq.size());
        chk("busy", busy, mq.size() != 0);
        chk("ready", wr_ready, mq.size() != DEPTH);
    endtask

    task automatic idle(input logic h);
        step(1'b0, 5'd0, 32'd0, 4'd0, h, 1'b0);
    endtask

    logic        cur_v;
    logic [4:0]  cur_a;
    logic [31:0] cur_d;
    logic [3:0]  cur_be;
    logic        cur_h;
    logic        cur_r;
    logic        was_acc;

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int k = 0; k < 32; k++) mregs[k] = '0;
        wr_valid = 0; wr_addr = 0; wr_data = 0; wr_be = 0; hold = 0; rst = 1;

        // Reset then idle
        step(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        chk("rst_qflat", q_flat, '0);
        chk("rst_pending", pending, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", wr_ready, 1'b1);

        // Single write, two-cycle latency
        step(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        chk("single_pend1", pending, 1);
        chk("single_r5_not_yet", reg_of(5), 32'h0);
        idle(1'b0);
        chk("single_r5", reg_of(5), 32'hDEADBEEF);
        chk("single_pend0", pending, 0);

        // Byte merge
        step(1'b1, 5'd7, 32'h11223344, 4'hF, 1'b0, 1'b0);
        idle(1'b0);
        step(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
        idle(1'b0);
        chk("merge_r7", reg_of(7), 32'h11BB33DD);

        // Hold and full, then in-order drain
        step(1'b1, 5'd1, 32'd1, 4'hF, 1'b1, 1'b0);
        step(1'b1, 5'd2, 32'd2, 4'hF, 1'b1, 1'b0);
        chk("full_pending", pending, 2);
        chk("full_ready", wr_ready, 1'b0);
        step(1'b1, 5'd3, 32'd3, 4'hF, 1'b1, 1'b0);
        chk("full_still", pending, 2);
        step(1'b1, 5'd3, 32'd3, 4'hF, 1'b0, 1'b0);
        chk("order_r1", reg_of(1), 32'd1);
        chk("order_r2_not_yet", reg_of(2), 32'd0);
        chk("order_r3_not_yet", reg_of(3), 32'd0);
        step(1'b1, 5'd3, 32'd3, 4'hF, 1'b0, 1'b0);
        chk("order_r2", reg_of(2), 32'd2);
        idle(1'b0);
        chk("order_r3", reg_of(3), 32'd3);
        chk("order_empty", pending, 0);

        // Register 0 stays zero
        step(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0);
        chk("r0_pend1", pending, 1);
        idle(1'b0);
        chk("r0_pend0", pending, 0);
        chk("r0_zero", reg_of(0), 32'd0);

        // Reset drops buffered writes
        step(1'b1, 5'd10, 32'h0000AAAA, 4'hF, 1'b1, 1'b0);
        step(1'b1, 5'd11, 32'h0000BBBB, 4'hF, 1'b1, 1'b0);
        step(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 1'b1);
        chk("rst_mid_pending", pending, 0);
        idle(1'b0);
        idle(1'b0);
        chk("rst_mid_r10", reg_of(10), 32'd0);
        chk("rst_mid_r11", reg_of(11), 32'd0);

        // Randomized traffic; sender holds a request until it is accepted
        cur_v = 0; cur_a = 0; cur_d = 0; cur_be = 0; was_acc = 1;
        for (int i = 0; i < 600; i++) begin
            if (was_acc || !cur_v) begin
                cur_v  = ($urandom_range(0, 3) != 0);
                cur_a  = 5'($urandom_range(0, 31));
                cur_d  = $urandom;
                cur_be = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            end
            cur_h   = ($urandom_range(0, 9) < 3);
            cur_r   = ($urandom_range(0, 99) == 0);
            was_acc = cur_r || (cur_v && (mq.size() < DEPTH));
            step(cur_v, cur_a, cur_d, cur_be, cur_h, cur_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
